// File: rtl/spi_slave_port.sv
// SPI mode-0 MSB-first slave: oversampled pins, one-word tx holding register, valid/ready rx output.
// Pin edges act 3 clk_i cycles late; a blocked rx drops the new word with an overrun pulse. SPI_SLAVE_RX_FIFO_EN adds an rx FIFO.
module spi_slave_port #(
  parameter int                DATA_W     = 8,
  parameter logic [DATA_W-1:0] TX_PAD     = {DATA_W{1'b1}},
  parameter int                FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              aresetn_i,
  input  logic              sclk_i,
  input  logic              cs_i,
  input  logic              mosi_i,
  output logic              miso_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam int              CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  logic [2:0] sclk_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;
  logic [2:0] vld_q;
  logic       armed_q;

  // armed_q only sets once cs_q holds a genuinely sampled high level, so a
  // frame already in progress when reset lifts is ignored until cs cycles.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      sclk_q  <= '0;
      cs_q    <= '1;
      mosi_q  <= '0;
      vld_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk_i};
      cs_q    <= {cs_q[1:0], cs_i};
      mosi_q  <= {mosi_q[0], mosi_i};
      vld_q   <= {vld_q[1:0], 1'b1};
      armed_q <= armed_q | (vld_q[2] & cs_q[2]);
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign cs_fall   = armed_q & cs_q[2] & ~cs_q[1];
  assign cs_rise   = cs_q[1] & ~cs_q[2];

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] tx_hold_q, tx_hold_d;
  logic              tx_full_q, tx_full_d;
  logic              overrun_q, overrun_d;
  logic [DATA_W-1:0] rx_word;
  logic              load, push;

  assign rx_word = {rx_shift_q[DATA_W-2:0], mosi_q[1]};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    load       = 1'b0;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (cs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (sclk_rise) begin
          rx_shift_d = rx_word;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            push      = 1'b1;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else if (sclk_fall) begin
          // A fall with bit_cnt at zero is the word boundary: fetch the next reply.
          if (bit_cnt_q != '0) tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          else                 load       = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (cs_rise) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      push      = 1'b0;
      load      = 1'b0;
    end
    if (load) begin
      tx_shift_d = tx_full_q ? tx_hold_q : TX_PAD;
      tx_full_d  = 1'b0;
    end
    if (tx_valid_i && !tx_full_q) begin
      tx_hold_d = tx_data_i;
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      tx_hold_q  <= '0;
      tx_full_q  <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      tx_hold_q  <= tx_hold_d;
      tx_full_q  <= tx_full_d;
      overrun_q  <= overrun_d;
    end
  end

  assign miso_o     = (state_q == ST_SHIFT) & tx_shift_q[DATA_W-1];
  assign tx_ready_o = ~tx_full_q;
  assign busy_o     = (state_q != ST_IDLE);
  assign overrun_o  = overrun_q;

`ifdef SPI_SLAVE_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic              fifo_empty, fifo_full, pop, push_ok;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && rx_ready_i;
  assign push_ok    = push && (!fifo_full || pop);
  assign overrun_d  = push && !push_ok;
  assign wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= rx_word;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  assign rx_valid_o = !fifo_empty;
  assign rx_data_o  = mem_q[rd_ptr_q[AW-1:0]];
`else
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    overrun_d  = 1'b0;
    if (push) begin
      if (!rx_valid_q || rx_ready_i) begin
        rx_data_d  = rx_word;
        rx_valid_d = 1'b1;
      end else begin
        overrun_d  = 1'b1;
      end
    end else if (rx_valid_q && rx_ready_i) begin
      rx_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
`endif

endmodule

// File: tb/tb_spi_slave_port.sv
// Directed bench for spi_slave_port: the bench plays the SPI master and the stream partners.
module tb_spi_slave_port;
  localparam int HALF = 8;

  logic       clk_i = 1'b0;
  logic       aresetn_i = 1'b0;
  logic       sclk_i = 1'b0;
  logic       cs_i = 1'b1;
  logic       mosi_i = 1'b0;
  logic [7:0] tx_data_i = 8'h00;
  logic       tx_valid_i = 1'b0;
  logic       rx_ready_i = 1'b0;
  logic       miso_o, tx_ready_o, rx_valid_o, busy_o, overrun_o;
  logic [7:0] rx_data_o;

  int n_checks = 0;
  int n_err = 0;
  int ovr_cnt = 0;
  logic [7:0] rx_got[$];

  typedef struct {
    logic       pre;
    logic [7:0] tx;
    logic [7:0] mosi;
    logic [7:0] exp_miso;
    logic [7:0] exp_rx;
  } vec_t;
  vec_t vecs[6];

  always #5 clk_i = ~clk_i;

  spi_slave_port dut (
    .clk_i(clk_i), .aresetn_i(aresetn_i), .sclk_i(sclk_i), .cs_i(cs_i), .mosi_i(mosi_i),
    .miso_o(miso_o), .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .busy_o(busy_o), .overrun_o(overrun_o)
  );

  always @(negedge clk_i) begin
    if (overrun_o) ovr_cnt <= ovr_cnt + 1;
    if (rx_valid_o && rx_ready_i) rx_got.push_back(rx_data_o);
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  task automatic preload(input logic [7:0] w);
    int t = 0;
    while (!tx_ready_o && t < 1000) begin
      wait_clk(1);
      t++;
    end
    if (!tx_ready_o) check("tx_ready_timeout", 32'd0, 32'd1);
    tx_data_i  = w;
    tx_valid_i = 1'b1;
    wait_clk(1);
    tx_valid_i = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int n, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < n; i++) begin
      mosi_i = mo[7-i];
      wait_clk(HALF);
      mi[7-i] = miso_o;
      sclk_i = 1'b1;
      wait_clk(HALF);
      sclk_i = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] mo, output logic [7:0] mi);
    cs_i = 1'b0;
    spi_bits(mo, 8, mi);
    wait_clk(HALF);
    cs_i = 1'b1;
    wait_clk(2 * HALF);
  endtask

  task automatic pop_rx();
    rx_ready_i = 1'b1;
    wait_clk(1);
    rx_ready_i = 1'b0;
  endtask

  initial begin
    logic [7:0] mi;
    logic [7:0] got_m[3];
    int ovr0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C};
    vecs[1] = '{1'b0, 8'h00, 8'h00, 8'hFF, 8'h00};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF};
    vecs[3] = '{1'b1, 8'h81, 8'h7E, 8'h81, 8'h7E};
    vecs[4] = '{1'b0, 8'h00, 8'h55, 8'hFF, 8'h55};
    vecs[5] = '{1'b1, 8'h96, 8'h69, 8'h96, 8'h69};

    wait_clk(3);
    aresetn_i = 1'b1;
    wait_clk(1);
    check("rst_miso", miso_o, 0);
    check("rst_tx_ready", tx_ready_o, 1);
    check("rst_rx_valid", rx_valid_o, 0);
    check("rst_rx_data", rx_data_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
    wait_clk(10);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].pre) begin
        preload(vecs[i].tx);
        check("vec_tx_ready_held", tx_ready_o, 0);
      end
      frame(vecs[i].mosi, mi);
      check("vec_master_rx", mi, vecs[i].exp_miso);
      check("vec_rx_valid", rx_valid_o, 1);
      check("vec_rx_data", rx_data_o, vecs[i].exp_rx);
      check("vec_tx_ready_after", tx_ready_o, 1);
      pop_rx();
    end

    // back-to-back words in one frame, replies fed as the holding register frees
    rx_got.delete();
    preload(8'hC1);
    rx_ready_i = 1'b1;
    fork
      begin
        preload(8'hC2);
        preload(8'hC3);
      end
      begin
        cs_i = 1'b0;
        spi_bits(8'h11, 8, got_m[0]);
        spi_bits(8'h22, 8, got_m[1]);
        spi_bits(8'h33, 8, got_m[2]);
        wait_clk(HALF);
        cs_i = 1'b1;
        wait_clk(2 * HALF);
      end
    join
    rx_ready_i = 1'b0;
    check("b2b_master_0", got_m[0], 8'hC1);
    check("b2b_master_1", got_m[1], 8'hC2);
    check("b2b_master_2", got_m[2], 8'hC3);
    check("b2b_rx_count", rx_got.size(), 3);
    for (int k = 0; k < 3; k++)
      check("b2b_rx_word", (rx_got.size() > k) ? rx_got[k] : 8'hxx, 8'(8'h11 * (k + 1)));

    // overrun with the consumer stalled
    ovr0 = ovr_cnt;
`ifdef SPI_SLAVE_RX_FIFO_EN
    for (int k = 1; k <= 5; k++) frame(8'(k), mi);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    for (int k = 1; k <= 4; k++) begin
      check("ovr_fifo_valid", rx_valid_o, 1);
      check("ovr_fifo_data", rx_data_o, k);
      pop_rx();
    end
`else
    frame(8'h01, mi);
    frame(8'h02, mi);
    check("ovr_pulses", ovr_cnt - ovr0, 1);
    check("ovr_valid", rx_valid_o, 1);
    check("ovr_kept_data", rx_data_o, 8'h01);
    pop_rx();
`endif
    check("ovr_drained", rx_valid_o, 0);

    // abort after 5 rises: partial word discarded, loaded reply consumed
    preload(8'hAB);
    ovr0 = ovr_cnt;
    cs_i = 1'b0;
    spi_bits(8'hF3, 5, mi);
    check("abort_busy", busy_o, 1);
    check("abort_partial_miso", mi[7:3], 5'b10101);
    wait_clk(HALF);
    cs_i = 1'b1;
    wait_clk(2 * HALF);
    check("abort_no_valid", rx_valid_o, 0);
    check("abort_no_overrun", ovr_cnt - ovr0, 0);
    check("abort_idle", busy_o, 0);
    check("abort_tx_freed", tx_ready_o, 1);
    frame(8'h7E, mi);
    check("abort_next_miso", mi, 8'hFF);
    check("abort_next_valid", rx_valid_o, 1);
    check("abort_next_data", rx_data_o, 8'h7E);
    pop_rx();

    // reset mid-word with a word pending on each side
    preload(8'h5A);
    frame(8'h33, mi);
    check("prerst_miso", mi, 8'h5A);
    preload(8'hE7);
    check("prerst_tx_ready", tx_ready_o, 0);
    cs_i = 1'b0;
    spi_bits(8'hF0, 3, mi);
    check("prerst_busy", busy_o, 1);
    aresetn_i = 1'b0;
    #1;
    check("midrst_miso", miso_o, 0);
    check("midrst_tx_ready", tx_ready_o, 1);
    check("midrst_rx_valid", rx_valid_o, 0);
    check("midrst_rx_data", rx_data_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_overrun", overrun_o, 0);
    wait_clk(2);
    aresetn_i = 1'b1;
    spi_bits(8'h0F, 5, mi);
    wait_clk(HALF);
    check("postrst_ignored_valid", rx_valid_o, 0);
    check("postrst_ignored_busy", busy_o, 0);
    cs_i = 1'b1;
    wait_clk(2 * HALF);
    preload(8'h69);
    frame(8'h96, mi);
    check("postrst_miso", mi, 8'h69);
    check("postrst_valid", rx_valid_o, 1);
    check("postrst_data", rx_data_o, 8'h96);
    pop_rx();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
